mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle RISC-V core between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the control unit/datapath and the memory. IF and LS each see a req/ack handshake.
- Provides alignment checking and a memory-ready watchdog, so a stalled or misaligned access cannot hang the control FSM.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 16, maximum cycles in ACCESS waiting for mem_ready before the access is aborted (must be 1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address (word access, read-only)
- if_ack  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DATA_W  fetched word, valid while if_ack=1
- ls_req  in  1  load/store request, held until ls_ack
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_we  in  1  1=store, 0=load
- ls_bytesel  in  3  funct3 size code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ls_ack  out  1  one-cycle pulse: load/store complete
- ls_rdata  out  DATA_W  load data, valid while ls_ack=1
- err  out  1  valid with either ack: access misaligned or timed out
- busy  out  1  state != IDLE
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_bytesel  out  3  size code to memory
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completes the access this cycle

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, wait counter=0, last owner=IF.
  - All outputs go to 0: acks, err, mem_en, mem_we, mem_addr, mem_wdata, mem_bytesel, if_rdata, ls_rdata, busy.
  - Reset mid-access abandons the memory transaction; no ack is issued for it.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, arbitrate, then register the owner, address, wdata, we and bytesel. IF always registers we=0 and bytesel=010.
  - Run the alignment check on the registered values:
    - Word: addr[1:0] must be 00.
    - Half/hu: addr[0] must be 0.
  - Misaligned: go to RESP with err pending; mem_en is never raised.
  - Aligned: go to ACCESS.
- ACCESS:
  - mem_en=1; mem_* are driven from the registered values and are stable for the whole state.
  - On mem_ready=1, capture mem_rdata and go to RESP.
  - Otherwise increment the wait counter. When the counter reaches MAX_WAIT, go to RESP with err=1 and rdata=0.
- RESP:
  - Pulse the owner's ack for exactly one cycle, with rdata and err valid; mem_en=0.
  - Update last owner, clear the counter, and return to IDLE.
- Latency from req seen in IDLE to ack, with a zero-wait memory (mem_ready in the first ACCESS cycle):
  - Edge 1: IDLE→ACCESS. Edge 2: ACCESS→RESP, with ack in that cycle. 3 cycles from req to ack.
  - Misaligned access: ack 2 cycles after req.
- Handshake rules:
  - Requesters must deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.
  - req inputs are ignored outside IDLE. Requester inputs are sampled only at grant.
- Arbitration with only one req high: that requester is granted.
- Arbitration with both reqs high: LS wins (fixed priority; see the optional feature). The loser keeps req high and is served next.
- Stores: mem_rdata is ignored; ls_rdata=0 on ack.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin on simultaneous requests. The requester that was not the last owner wins; last owner resets to IF, so the first tie goes to LS.
- Undefined: fixed priority, LS always wins. last owner is still tracked but unused.

Decomposition:
- Package mem_arb_pkg holds:
  - State enum {IDLE, ACCESS, RESP}.
  - Owner enum {OWN_IF, OWN_LS}.
  - Size localparams SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101.
- One sub-module, mem_arb_align_chk: combinational; takes addr[1:0] and bytesel, outputs misaligned.

Test Plan:
- IF only, addr 0x100, mem_ready in the first ACCESS cycle, mem_rdata=0x00500093.
  - if_ack exactly 3 cycles after req, if_rdata=0x00500093, err=0, mem_en high for 1 cycle.
- LS store: addr 0x204, wdata 0xDEADBEEF, bytesel 010, mem_ready delayed 4 cycles.
  - mem_we=1 and mem_addr/mem_wdata stable for 5 cycles, then ls_ack with ls_rdata=0.
- Both reqs high at the same cycle.
  - Without the macro: LS acked first, then IF.
  - With MEM_ARB_RR_EN, two back-to-back ties: LS, IF, LS, IF order.
- LS load, bytesel 001, addr 0x203.
  - ls_ack 2 cycles after req, err=1, mem_en never asserted.
- mem_ready held low, MAX_WAIT=16.
  - Ack with err=1 after 16 ACCESS cycles; mem_en drops in RESP.
- rst=0 asserted in the 2nd ACCESS cycle.
  - Next cycle all outputs are 0 and state is IDLE.
  - A still-high if_req after rst=1 is re-served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and size codes for the unified memory-port arbiter.
// Round-robin tie-breaking is selected at build time with MEM_ARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Unknown size codes are passed through untouched and never flagged.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_W:        bad = (addr_lo != 2'b00);
            SZ_H, SZ_HU: bad = addr_lo[0];
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arb_align_chk.sv
// Combinational alignment checker: flags word accesses not on a 4-byte
// boundary and halfword accesses not on a 2-byte boundary.
module mem_arb_align_chk
    import mem_arb_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] bytesel,
    output logic       misaligned
);

    assign misaligned = is_misaligned(addr_lo, bytesel);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core's single memory port between instruction fetch and load/store,
// with alignment checking and a mem_ready watchdog. Define MEM_ARB_RR_EN for round-robin ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic              ls_we,
    input  logic [2:0]        ls_bytesel,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_bytesel,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    state_t            state;
    owner_t            owner;
    owner_t            last_owner;
    logic [7:0]        wait_cnt;

    logic              grant_ls;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
    logic              grant_we;
    logic [2:0]        grant_sel;
    logic              misaligned;

    // LS wins a tie unless round-robin says IF is due (LS was served last).
    always_comb begin
        grant_ls    = ls_req && (!if_req || !RR_MODE || (last_owner == OWN_IF));
        grant_addr  = grant_ls ? ls_addr    : if_addr;
        grant_wdata = grant_ls ? ls_wdata   : '0;
        grant_we    = grant_ls && ls_we;
        grant_sel   = grant_ls ? ls_bytesel : SZ_W;
    end

    // Checked on the values being captured this edge, i.e. what ends up registered.
    mem_arb_align_chk u_align_chk (
        .addr_lo    (grant_addr[1:0]),
        .bytesel    (grant_sel),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            last_owner  <= OWN_IF;
            wait_cnt    <= '0;
            if_ack      <= 1'b0;
            ls_ack      <= 1'b0;
            if_rdata    <= '0;
            ls_rdata    <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_bytesel <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || ls_req) begin
                        owner       <= grant_ls ? OWN_LS : OWN_IF;
                        mem_addr    <= grant_addr;
                        mem_wdata   <= grant_wdata;
                        mem_bytesel <= grant_sel;
                        wait_cnt    <= '0;
                        busy        <= 1'b1;
                        if (misaligned) begin
                            state  <= RESP;
                            err    <= 1'b1;
                            if_ack <= !grant_ls;
                            ls_ack <= grant_ls;
                        end else begin
                            state  <= ACCESS;
                            mem_en <= 1'b1;
                            mem_we <= grant_we;
                        end
                    end
                end

                ACCESS: begin
                    if (mem_ready) begin
                        state  <= RESP;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner == OWN_LS) begin
                            ls_ack   <= 1'b1;
                            ls_rdata <= mem_we ? '0 : mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        // Watchdog: abort so a dead memory cannot wedge the control FSM.
                        if ((wait_cnt + 8'd1) == WAIT_MAX) begin
                            state  <= RESP;
                            mem_en <= 1'b0;
                            mem_we <= 1'b0;
                            err    <= 1'b1;
                            if_ack <= (owner == OWN_IF);
                            ls_ack <= (owner == OWN_LS);
                        end
                    end
                end

                RESP: begin
                    state      <= IDLE;
                    last_owner <= owner;
                    wait_cnt   <= '0;
                    if_ack     <= 1'b0;
                    ls_ack     <= 1'b0;
                    if_rdata   <= '0;
                    ls_rdata   <= '0;
                    err        <= 1'b0;
                    busy       <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expectations are queued at request time
// and popped when an ack appears. Tie ordering follows MEM_ARB_RR_EN when defined.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req = 1'b0;
    logic [ADDR_W-1:0] ls_addr = '0;
    logic [DATA_W-1:0] ls_wdata = '0;
    logic              ls_we = 1'b0;
    logic [2:0]        ls_bytesel = 3'b010;
    logic              ls_ack;
    logic [DATA_W-1:0] ls_rdata;
    logic              err;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_bytesel;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ack      (if_ack),
        .if_rdata    (if_rdata),
        .ls_req      (ls_req),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_we       (ls_we),
        .ls_bytesel  (ls_bytesel),
        .ls_ack      (ls_ack),
        .ls_rdata    (ls_rdata),
        .err         (err),
        .busy        (busy),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_bytesel (mem_bytesel),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    typedef struct packed {
        logic        is_ls;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Memory responder: ready after mem_lat stalled cycles (-1 = never); read data depends on address.
    int          mem_lat = 0;
    logic [31:0] mem_data = '0;
    int          acc_cnt = 0;
    int          en_cycles = 0;
    bit          unstable = 1'b0;
    logic [31:0] snap_addr = '0;
    logic [31:0] snap_wdata = '0;
    logic        snap_we = 1'b0;
    logic [2:0]  snap_sel = '0;

    assign mem_rdata = mem_data ^ mem_addr;

    always @(negedge clk) begin
        if (mem_en) begin
            if (acc_cnt == 0) begin
                snap_addr  = mem_addr;
                snap_wdata = mem_wdata;
                snap_we    = mem_we;
                snap_sel   = mem_bytesel;
            end else if ({mem_addr, mem_wdata, mem_we, mem_bytesel} !== {snap_addr, snap_wdata, snap_we, snap_sel}) begin
                unstable = 1'b1;
            end
            mem_ready = (mem_lat >= 0) && (acc_cnt == mem_lat);
            acc_cnt++;
            en_cycles++;
        end else begin
            mem_ready = 1'b0;
            acc_cnt   = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_meters();
        en_cycles = 0;
        unstable  = 1'b0;
    endtask

    // Latency counts the cycle the request is first driven as cycle 1.
    task automatic wait_ack(input int budget, output int lat, output bit timed_out);
        lat       = 1;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            lat++;
            if (if_ack || ls_ack) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({if_ack, ls_ack, err, busy, mem_en, mem_we} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 000000", {if_ack, ls_ack, err, busy, mem_en, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_bytesel} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_mem: got addr %h wdata %h sel %b, expected zeros", mem_addr, mem_wdata, mem_bytesel);
        end
        checks++;
        if ({if_rdata, ls_rdata} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_rdata: got %h/%h, expected 0/0", if_rdata, ls_rdata);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_if_fetch();
        int lat;
        bit to;
        exp_t e;
        mem_lat  = 0;
        mem_data = 32'h0050_0093 ^ 32'h100;
        reset_meters();
        exp_q.push_back({1'b0, 32'h0050_0093, 1'b0});
        if_addr = 32'h100;
        if_req  = 1'b1;
        wait_ack(40, lat, to);
        checks++;
        if (to || lat != 3) begin
            fails++;
            $display("[TB] FAIL fetch_latency: got %0d (timeout %0d), expected 3", lat, to);
        end
        if (!to && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({ls_ack, if_ack} !== (e.is_ls ? 2'b10 : 2'b01)) begin
                fails++;
                $display("[TB] FAIL fetch_owner: got ls/if %b%b, expected is_ls %0d", ls_ack, if_ack, e.is_ls);
            end
            checks++;
            if (if_rdata !== e.rdata) begin
                fails++;
                $display("[TB] FAIL fetch_rdata: got %h, expected %h", if_rdata, e.rdata);
            end
            checks++;
            if (err !== e.err) begin
                fails++;
                $display("[TB] FAIL fetch_err: got %b, expected %b", err, e.err);
            end
        end
        checks++;
        if (en_cycles != 1 || mem_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL fetch_mem_en: got %0d cycles, mem_en at ack %b, expected 1 and 0", en_cycles, mem_en);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_ls_store();
        int lat;
        bit to;
        exp_t e;
        mem_lat = 4;
        reset_meters();
        exp_q.push_back({1'b1, 32'h0, 1'b0});
        ls_addr    = 32'h204;
        ls_wdata   = 32'hDEAD_BEEF;
        ls_we      = 1'b1;
        ls_bytesel = 3'b010;
        ls_req     = 1'b1;
        wait_ack(40, lat, to);
        checks++;
        if (to || lat != 7) begin
            fails++;
            $display("[TB] FAIL store_latency: got %0d (timeout %0d), expected 7", lat, to);
        end
        if (!to && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({ls_ack, if_ack} !== (e.is_ls ? 2'b10 : 2'b01)) begin
                fails++;
                $display("[TB] FAIL store_owner: got ls/if %b%b, expected is_ls %0d", ls_ack, if_ack, e.is_ls);
            end
            checks++;
            if (ls_rdata !== e.rdata || err !== e.err) begin
                fails++;
                $display("[TB] FAIL store_resp: got rdata %h err %b, expected %h %b", ls_rdata, err, e.rdata, e.err);
            end
        end
        checks++;
        if (en_cycles != 5 || unstable) begin
            fails++;
            $display("[TB] FAIL store_window: got %0d cycles unstable %0d, expected 5 and 0", en_cycles, unstable);
        end
        checks++;
        if ({snap_we, snap_addr, snap_wdata, snap_sel} !== {1'b1, 32'h204, 32'hDEAD_BEEF, 3'b010}) begin
            fails++;
            $display("[TB] FAIL store_mem_bus: got we %b addr %h wdata %h sel %b, expected 1 204 deadbeef 010", snap_we, snap_addr, snap_wdata, snap_sel);
        end
        ls_req = 1'b0;
        ls_we  = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        int lat;
        bit to;
        exp_t e;
        mem_lat = 0;
        reset_meters();
        exp_q.push_back({1'b1, 32'h0, 1'b1});
        ls_addr    = 32'h203;
        ls_we      = 1'b0;
        ls_bytesel = 3'b001;
        ls_req     = 1'b1;
        wait_ack(40, lat, to);
        checks++;
        if (to || lat != 2) begin
            fails++;
            $display("[TB] FAIL misalign_latency: got %0d (timeout %0d), expected 2", lat, to);
        end
        if (!to && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ls_ack !== e.is_ls || err !== e.err || ls_rdata !== e.rdata) begin
                fails++;
                $display("[TB] FAIL misalign_resp: got ack %b err %b rdata %h, expected %b %b %h", ls_ack, err, ls_rdata, e.is_ls, e.err, e.rdata);
            end
        end
        checks++;
        if (en_cycles != 0) begin
            fails++;
            $display("[TB] FAIL misalign_mem_en: got %0d cycles, expected 0", en_cycles);
        end
        ls_req     = 1'b0;
        ls_bytesel = 3'b010;
        tick();
    endtask

    task automatic test_timeout();
        int lat;
        bit to;
        exp_t e;
        mem_lat = -1;
        reset_meters();
        exp_q.push_back({1'b0, 32'h0, 1'b1});
        if_addr = 32'h40;
        if_req  = 1'b1;
        wait_ack(60, lat, to);
        checks++;
        if (to || lat != MAX_WAIT + 2) begin
            fails++;
            $display("[TB] FAIL timeout_latency: got %0d (timeout %0d), expected %0d", lat, to, MAX_WAIT + 2);
        end
        if (!to && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (if_ack !== 1'b1 || ls_ack !== e.is_ls || err !== e.err || if_rdata !== e.rdata) begin
                fails++;
                $display("[TB] FAIL timeout_resp: got ack %b/%b err %b rdata %h, expected if ack, err %b rdata %h", if_ack, ls_ack, err, if_rdata, e.err, e.rdata);
            end
        end
        checks++;
        if (en_cycles != MAX_WAIT || mem_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL timeout_mem_en: got %0d cycles, mem_en at ack %b, expected %0d and 0", en_cycles, mem_en, MAX_WAIT);
        end
        if_req = 1'b0;
        tick();
    endtask

    // Simultaneous requests with IF having been served last: LS goes first in either mode.
    task automatic test_tie();
        int lat;
        bit to;
        exp_t e;
        mem_lat    = 0;
        mem_data   = 32'h1111_0000;
        exp_q.push_back({1'b1, 32'h1111_0000 ^ 32'h300, 1'b0});
        exp_q.push_back({1'b0, 32'h1111_0000 ^ 32'h80, 1'b0});
        if_addr    = 32'h80;
        ls_addr    = 32'h300;
        ls_we      = 1'b0;
        ls_bytesel = 3'b010;
        if_req     = 1'b1;
        ls_req     = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_ack(40, lat, to);
            checks++;
            if (to || exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL tie_ack_%0d: got timeout %0d queue %0d, expected an ack", k, to, exp_q.size());
                break;
            end
            e = exp_q.pop_front();
            checks++;
            if ({ls_ack, if_ack} !== (e.is_ls ? 2'b10 : 2'b01) || (e.is_ls ? ls_rdata : if_rdata) !== e.rdata) begin
                fails++;
                $display("[TB] FAIL tie_order_%0d: got ls/if %b%b rdata %h/%h, expected is_ls %0d rdata %h", k, ls_ack, if_ack, ls_rdata, if_rdata, e.is_ls, e.rdata);
            end
            if (if_ack) if_req = 1'b0;
            if (ls_ack) ls_req = 1'b0;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        tick();
    endtask

    // LS served alone, then an immediate tie: round-robin hands the tie to IF.
    task automatic test_back_to_back();
        int lat;
        bit to;
        exp_t e;
        mem_lat  = 0;
        mem_data = 32'h2222_0000;
        exp_q.push_back({1'b1, 32'h2222_0000 ^ 32'h310, 1'b0});
`ifdef MEM_ARB_RR_EN
        exp_q.push_back({1'b0, 32'h2222_0000 ^ 32'h90, 1'b0});
        exp_q.push_back({1'b1, 32'h2222_0000 ^ 32'h310, 1'b0});
`else
        exp_q.push_back({1'b1, 32'h2222_0000 ^ 32'h310, 1'b0});
        exp_q.push_back({1'b0, 32'h2222_0000 ^ 32'h90, 1'b0});
`endif
        if_addr = 32'h90;
        ls_addr = 32'h310;
        ls_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(40, lat, to);
            checks++;
            if (to || exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL b2b_ack_%0d: got timeout %0d queue %0d, expected an ack", k, to, exp_q.size());
                break;
            end
            e = exp_q.pop_front();
            checks++;
            if ({ls_ack, if_ack} !== (e.is_ls ? 2'b10 : 2'b01) || (e.is_ls ? ls_rdata : if_rdata) !== e.rdata) begin
                fails++;
                $display("[TB] FAIL b2b_order_%0d: got ls/if %b%b rdata %h/%h, expected is_ls %0d rdata %h", k, ls_ack, if_ack, ls_rdata, if_rdata, e.is_ls, e.rdata);
            end
            if (if_ack) if_req = 1'b0;
            if (ls_ack) ls_req = 1'b0;
            if (k == 0) begin
                tick();
                if_req = 1'b1;
                ls_req = 1'b1;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        exp_t e;
        mem_lat = -1;
        if_addr = 32'h44;
        if_req  = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || mem_en !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midrst_access: got busy %b mem_en %b, expected 1 1", busy, mem_en);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({if_ack, ls_ack, err, busy, mem_en, mem_we, mem_addr, mem_wdata, mem_bytesel, if_rdata, ls_rdata} !== '0) begin
            fails++;
            $display("[TB] FAIL midrst_outputs: got ack %b%b err %b busy %b en %b we %b addr %h, expected all zero", if_ack, ls_ack, err, busy, mem_en, mem_we, mem_addr);
        end
        rst      = 1'b1;
        mem_lat  = 0;
        mem_data = 32'hABCD_0000;
        exp_q.push_back({1'b0, 32'hABCD_0000 ^ 32'h44, 1'b0});
        wait_ack(40, lat, to);
        checks++;
        if (to || lat != 3) begin
            fails++;
            $display("[TB] FAIL midrst_reserve_latency: got %0d (timeout %0d), expected 3", lat, to);
        end
        if (!to && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (if_ack !== 1'b1 || if_rdata !== e.rdata || err !== e.err) begin
                fails++;
                $display("[TB] FAIL midrst_reserve_resp: got ack %b rdata %h err %b, expected 1 %h %b", if_ack, if_rdata, err, e.rdata, e.err);
            end
        end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_if_fetch();
        test_ls_store();
        test_misaligned();
        test_timeout();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
